// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the register file and the writeback
// destination decoder that drives it.
//   NUM_REGS   - number of architectural registers
//   REG_ADDR_W - register address width
//   DATA_W     - default register width
//   sel_vec_t  - one-hot write-select vector from the destination decoder
package cpu_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef logic [NUM_REGS-1:0] sel_vec_t;

endpackage

// File: rtl/onehot_check.sv
// onehot_check: combinational classification of a decoder select vector.
// Ports:
//   sel   in  NUM_REGS  select vector to classify
//   none  out 1         no bit set
//   one   out 1         exactly one bit set
//   multi out 1         two or more bits set
module onehot_check
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0] sel,
  output logic                none,
  output logic                one,
  output logic                multi
);

  sel_vec_t sel_minus1;

  // Clearing the lowest set bit leaves something only when more than one
  // bit was set.
  assign sel_minus1 = sel - sel_vec_t'(1);
  assign none       = (sel == '0);
  assign multi      = ((sel & sel_minus1) != '0);
  assign one        = !none && !multi;

endmodule

// File: rtl/reg_file16.sv
// reg_file16: 16-entry general-purpose register file with two combinational
// read ports, per-entry written-since-reset flags, a sticky multi-hot
// write-select error flag and a saturating committed-write counter.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   wr_sel      in   one-hot write select (all-zero = no write)
//   wr_data     in   write data
//   rd_addr_a/b in   read addresses
//   clr_err     in   synchronous clear of sel_err
//   rd_data_a/b out  read data
//   rd_valid_a/b out entry written since reset
//   sel_err     out  sticky multi-hot select seen
//   wr_count    out  committed writes since reset, saturating at 16'hFFFF
// Build option: define REG_FILE16_BYPASS_EN to forward same-cycle write data
// to a read port addressing the entry being written.
module reg_file16
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REGS-1:0]   wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  input  logic                  clr_err,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b,
  output logic                  sel_err,
  output logic [15:0]           wr_count
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  logic                sel_err_q;
  logic [15:0]         wr_count_q;

  logic wr_none;
  logic wr_ok;
  logic wr_multi;

  onehot_check u_onehot_check (
    .sel   (wr_sel),
    .none  (wr_none),
    .one   (wr_ok),
    .multi (wr_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      valid_q    <= '0;
      sel_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      // Only a clean one-hot select commits; a multi-hot select touches no entry.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_sel[i]) begin
          regs_q[i]  <= wr_data;
          valid_q[i] <= 1'b1;
        end
      end
      if (wr_ok && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      // A new error on the same edge as a clear request keeps the flag set.
      if (wr_multi) begin
        sel_err_q <= 1'b1;
      end else if (clr_err) begin
        sel_err_q <= 1'b0;
      end
    end
  end

`ifdef REG_FILE16_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // Gated by rst_n so the ports still read zero while reset is held.
  assign byp_a = rst_n && wr_ok && wr_sel[rd_addr_a];
  assign byp_b = rst_n && wr_ok && wr_sel[rd_addr_b];

  assign rd_data_a  = byp_a ? wr_data : regs_q[rd_addr_a];
  assign rd_data_b  = byp_b ? wr_data : regs_q[rd_addr_b];
  assign rd_valid_a = byp_a | valid_q[rd_addr_a];
  assign rd_valid_b = byp_b | valid_q[rd_addr_b];
`else
  assign rd_data_a  = regs_q[rd_addr_a];
  assign rd_data_b  = regs_q[rd_addr_b];
  assign rd_valid_a = valid_q[rd_addr_a];
  assign rd_valid_b = valid_q[rd_addr_b];
`endif

  assign sel_err  = sel_err_q;
  assign wr_count = wr_count_q;

  // wr_none is part of the shared classifier interface; a zero select needs
  // no action here.
  logic unused_none;
  assign unused_none = wr_none;

endmodule
